// File: rtl/aes_key_expansion_if.sv
// Control, key load and round-key read port of the AES-128 key schedule.
// The master drives requests and addresses; the slave (key schedule) returns status and keys.
interface aes_key_expansion_if;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         key_valid;
  logic [3:0]   rk_addr;
  logic [127:0] rk_out;

  modport master (
    output start, key_in, rk_addr,
    input  busy, done, key_valid, rk_out
  );

  modport slave (
    input  start, key_in, rk_addr,
    output busy, done, key_valid, rk_out
  );
endinterface

// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry store,
// served through a registered read port addressed by round number.

// Forward AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] m;
    p = '0;
    m = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ m;
      m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 == x^-1 for x != 0, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < 6; i++) begin
      r = gf_mul(gf_mul(r, r), x);
    end
    return gf_mul(r, r);
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  assign s = affine(gf_inv(a));
endmodule

module aes_key_expansion (
  input  logic                 clk,
  input  logic                 rst,
  aes_key_expansion_if.slave   bus
);
  localparam int unsigned KW     = 128;
  localparam int unsigned NRK    = 11;
  localparam int unsigned LAST_R = 10;

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t      state;
  logic [3:0]  rnd;
  logic [KW-1:0] rk [NRK];
  logic        busy_q;
  logic        done_q;
  logic        key_valid_q;
  logic [KW-1:0] rk_out_q;

  logic [KW-1:0] prev_rk;
  logic [KW-1:0] next_rk;
  logic [KW-1:0] rd_data;
  logic [7:0]    rcon;
  logic [31:0]   rot_w;
  logic [31:0]   sub_w;
  logic [31:0]   t_w;
  logic [31:0]   n0, n1, n2, n3;

  // Previous round key feeding the schedule step
  always_comb begin
    prev_rk = '0;
    if (rnd != 4'd0 && rnd <= 4'(LAST_R)) prev_rk = rk[rnd - 4'd1];
  end

  always_comb begin
    rcon = 8'h00;
    case (rnd)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign rot_w = {prev_rk[23:0], prev_rk[31:24]};

  aes_sbox u_sbox0 (.a(rot_w[31:24]), .s(sub_w[31:24]));
  aes_sbox u_sbox1 (.a(rot_w[23:16]), .s(sub_w[23:16]));
  aes_sbox u_sbox2 (.a(rot_w[15:8]),  .s(sub_w[15:8]));
  aes_sbox u_sbox3 (.a(rot_w[7:0]),   .s(sub_w[7:0]));

  assign t_w     = sub_w ^ {rcon, 24'h000000};
  assign n0      = prev_rk[127:96] ^ t_w;
  assign n1      = prev_rk[95:64]  ^ n0;
  assign n2      = prev_rk[63:32]  ^ n1;
  assign n3      = prev_rk[31:0]   ^ n2;
  assign next_rk = {n0, n1, n2, n3};

  // Out-of-range addresses read as zero
  always_comb begin
    rd_data = '0;
    if (bus.rk_addr <= 4'(LAST_R)) rd_data = rk[bus.rk_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rnd         <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_valid_q <= 1'b0;
      rk_out_q    <= '0;
      for (int i = 0; i < int'(NRK); i++) rk[i] <= '0;
    end else begin
      done_q   <= 1'b0;
      rk_out_q <= rd_data;
      case (state)
        IDLE: begin
          if (bus.start) begin
            rk[0]       <= bus.key_in;
            rnd         <= 4'd1;
            state       <= EXPAND;
            busy_q      <= 1'b1;
            key_valid_q <= 1'b0;
          end
        end
        EXPAND: begin
          rk[rnd] <= next_rk;
          if (rnd == 4'(LAST_R)) begin
            state       <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            key_valid_q <= 1'b1;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.key_valid = key_valid_q;
  assign bus.rk_out    = rk_out_q;
endmodule

// File: tb/tb_aes_key_expansion.sv
// Bench for aes_key_expansion: a word-level FIPS-197 key schedule model drives a
// per-cycle compare of busy/done/key_valid/rk_out, pinned by hand-computed literals.
module tb_aes_key_expansion;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_key_expansion_if bus();

  aes_key_expansion dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]          sb [256];
  logic [10:0][127:0]  m_rk;
  logic [10:0][127:0]  sched;
  logic                m_busy, m_done, m_kv;
  logic [127:0]        m_out;
  int                  m_n;
  bit                  m_live = 1'b0;

  localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_B    = 128'h000102030405060708090a0b0c0d0e0f;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box table from exp/log tables over generator 3, then the bitwise affine rule
  task automatic build_sbox();
    int         lg [256];
    logic [7:0] ex [256];
    logic [7:0] e, b, c, s;
    e = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = e;
      lg[e] = i;
      e = e ^ xt(e);
    end
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      b = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
      for (int k = 0; k < 8; k++)
        s[k] = b[k] ^ b[(k+4)%8] ^ b[(k+5)%8] ^ b[(k+6)%8] ^ b[(k+7)%8] ^ c[k];
      sb[x] = s;
    end
  endtask

  function automatic logic [10:0][127:0] expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [10:0][127:0] r;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 11; j++) r[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Cycle model: whole schedule computed at accept, one stored key revealed per edge
  always @(posedge clk) begin
    m_out = (bus.rk_addr <= 4'd10) ? m_rk[bus.rk_addr] : 128'h0;
    if (rst) begin
      m_live = 1'b1;
      m_busy = 1'b0; m_done = 1'b0; m_kv = 1'b0; m_n = 0;
      m_rk   = '0;   m_out  = '0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_rk[m_n] = sched[m_n];
        if (m_n == 10) begin
          m_busy = 1'b0; m_done = 1'b1; m_kv = 1'b1;
        end else begin
          m_n = m_n + 1;
        end
      end else if (bus.start) begin
        sched   = expand(bus.key_in);
        m_rk[0] = sched[0];
        m_n     = 1;
        m_busy  = 1'b1;
        m_kv    = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("busy",      128'(bus.busy),      128'(m_busy));
      chk("done",      128'(bus.done),      128'(m_done));
      chk("key_valid", 128'(bus.key_valid), 128'(m_kv));
      chk("rk_out",    bus.rk_out,          m_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic go(input logic [127:0] k);
    bus.key_in = k;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
  endtask

  // Waits for done with a cycle budget; garbles key_in meanwhile
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!bus.done && cyc < 30) begin
      bus.key_in = {$urandom, $urandom, $urandom, $urandom};
      tick();
      cyc++;
    end
  endtask

  task automatic read_rk(input logic [3:0] a, output logic [127:0] v);
    bus.rk_addr = a;
    tick();
    v = bus.rk_out;
  endtask

  initial begin
    logic [10:0][127:0] kf, kz, kb;
    logic [127:0] v;
    int cyc, nd;
    logic [3:0] addrs [13];

    rst = 1'b1; bus.start = 1'b0; bus.key_in = '0; bus.rk_addr = '0;
    build_sbox();
    chk("sbox_00", 128'(sb[8'h00]), 128'h63);
    chk("sbox_53", 128'(sb[8'h53]), 128'hed);
    kf = expand(K_FIPS);
    kz = expand(128'h0);
    kb = expand(K_B);
    chk("model_fips_rk1",  kf[1],  128'ha0fafe1788542cb123a339392a6c7605);
    chk("model_fips_rk10", kf[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("model_zero_rk1",  kz[1],  128'h62636363626363636263636362636363);
    chk("model_zero_rk10", kz[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    tick(); tick();
    rst = 1'b0;
    tick();

    // FIPS key: latency, then the full read sweep including out-of-range addresses
    go(K_FIPS);
    wait_done(cyc);
    chk("fips_latency", 128'(cyc), 128'd10);
    for (int i = 0; i < 11; i++) addrs[i] = 4'(i);
    addrs[11] = 4'd11;
    addrs[12] = 4'd15;
    for (int i = 0; i < 13; i++) begin
      read_rk(addrs[i], v);
      if (i == 0)       chk("rd_rk0",  v, K_FIPS);
      else if (i == 1)  chk("rd_rk1",  v, 128'ha0fafe1788542cb123a339392a6c7605);
      else if (i == 10) chk("rd_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      else if (i > 10)  chk("rd_oob",  v, 128'h0);
      else              chk("rd_rkn",  v, kf[i]);
    end

    // All-zero key
    go(128'h0);
    wait_done(cyc);
    chk("zero_latency", 128'(cyc), 128'd10);
    read_rk(4'd1, v);  chk("zero_rk1",  v, 128'h62636363626363636263636362636363);
    read_rk(4'd10, v); chk("zero_rk10", v, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Start with another key in cycle 4 of an expansion is ignored
    go(K_FIPS);
    tick(); tick();
    bus.key_in = K_B;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    wait_done(cyc);
    chk("ignore_latency", 128'(cyc), 128'd7);
    read_rk(4'd1, v);  chk("ignore_rk1",  v, kf[1]);
    read_rk(4'd10, v); chk("ignore_rk10", v, kf[10]);

    // Start accepted in the done cycle
    go(K_FIPS);
    wait_done(cyc);
    chk("redo_first_done", 128'(bus.done), 128'd1);
    go(K_B);
    chk("redo_kv_drop", 128'(bus.key_valid), 128'd0);
    wait_done(cyc);
    chk("redo_latency", 128'(cyc), 128'd10);
    chk("redo_kv_rise", 128'(bus.key_valid), 128'd1);
    read_rk(4'd0, v);  chk("redo_rk0",  v, K_B);
    read_rk(4'd10, v); chk("redo_rk10", v, kb[10]);

    // Reset mid-expansion, with start held: everything cleared, no done follows
    go(K_FIPS);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    bus.start = 1'b1;
    bus.key_in = K_B;
    tick();
    chk("rst_busy", 128'(bus.busy),      128'd0);
    chk("rst_done", 128'(bus.done),      128'd0);
    chk("rst_kv",   128'(bus.key_valid), 128'd0);
    chk("rst_out",  bus.rk_out,          128'h0);
    rst = 1'b0;
    bus.start = 1'b0;
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.done) nd++;
    end
    chk("rst_no_done", 128'(nd), 128'd0);
    read_rk(4'd0, v); chk("rst_rk0_clear", v, 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
